fsic_io_serdes_rx_align_ctrl: RTL and testbench
===============================================

FSIC_IO_SERDES_RX_ALIGN_CTRL -- requirements
Module: fsic_io_serdes_rx_align_ctrl

Interface
REQ-001 Parameters SHALL be: pCLK_RATIO, 4, word width; pTRAIN_PATTERN, 4'b0011, training word (all 4 rotations distinct); pLOCK_CNT, 8, consecutive matches to lock; pVALID_TIMEOUT, 64, cycles to wait for valid; pBACKOFF, 16, rxen-low cycles between attempts.
REQ-002 coreclk  input  1  sole clock; all logic on rising edge.
REQ-003 axis_rst  input  1  reset, synchronous, active-high.
REQ-004 align_en  input  1  level; 1 = run training/link, 0 = idle.
REQ-005 retrain  input  1  single-cycle request to drop lock and retrain.
REQ-006 rxdata_out  input  pCLK_RATIO  word from serdes rx, LSB = earliest bit.
REQ-007 rxdata_out_valid  input  1  word valid, one new word per coreclk while high.
REQ-008 rxen  output  1  enable to serdes rx.
REQ-009 aligned_data  output  pCLK_RATIO  bit-slipped word.
REQ-010 aligned_valid  output  1  aligned_data valid (LOCKED only).
REQ-011 link_up  output  1  high in LOCKED.
REQ-012 slip  output  2  current bit-slip offset 0..3.
REQ-013 train_fail  output  1  one-cycle pulse per failed attempt.

Function
REQ-014 prev_word SHALL register rxdata_out on every cycle rxdata_out_valid=1; cat = {rxdata_out, prev_word} (8 bits); candidate[i] = cat[i+slip], i=0..3.
REQ-015 FSM states SHALL be IDLE, ENABLE, SEARCH, LOCKED, BACKOFF; encoding free.
REQ-016 IDLE: rxen=0, slip=0, match_cnt=0; align_en=1 -> ENABLE.
REQ-017 ENABLE: rxen=1, timer counts cycles; rxdata_out_valid=1 -> SEARCH (timer cleared); timer reaching pVALID_TIMEOUT-1 without valid -> BACKOFF with train_fail pulse.
REQ-018 SEARCH (rxen=1): per valid cycle, candidate==pTRAIN_PATTERN -> match_cnt+1; match_cnt reaching pLOCK_CNT -> LOCKED; mismatch -> match_cnt=0, slip+1; mismatch at slip=3 -> BACKOFF, slip=0, train_fail pulse; cycles with valid=0 hold all counters.
REQ-019 LOCKED: rxen=1, link_up=1, slip frozen; aligned_data=candidate registered, aligned_valid=registered rxdata_out_valid; latency 1 coreclk from rxdata_out to aligned_data.
REQ-020 LOCKED exit: retrain=1 or rxdata_out_valid=0 -> BACKOFF (no train_fail); link_up and aligned_valid low the next cycle.
REQ-021 BACKOFF: rxen=0, counter runs pBACKOFF cycles then -> ENABLE; slip and match_cnt cleared on entry.
REQ-022 align_en=0 in any state SHALL force IDLE next cycle and has priority over retrain and all other transitions.
REQ-023 retrain outside LOCKED SHALL be ignored.
REQ-024 Outside LOCKED aligned_data SHALL hold 0 and aligned_valid 0.
REQ-025 All counters SHALL be sized to their parameter via $clog2 and never wrap past their terminal value.

Reset
REQ-026 axis_rst=1 at a rising edge SHALL force IDLE and clear prev_word, timers, match_cnt, slip, retry count.
REQ-027 Reset values: rxen=0, aligned_data=0, aligned_valid=0, link_up=0, slip=0, train_fail=0.
REQ-028 Reset asserted mid-SEARCH or mid-LOCKED SHALL take effect the same edge, with no train_fail pulse.

Configuration
REQ-029 Macro FSIC_RX_ALIGN_RETRY_CNT_EN: when defined, adds output retry_cnt [7:0], incremented on each train_fail pulse, saturating at 255, cleared by reset only.
REQ-030 Without FSIC_RX_ALIGN_RETRY_CNT_EN the retry_cnt port and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, align_en=1, valid high from cycle 3, stream 4'b0011 at slip 0 -> link_up=1 after 8 matching words, slip=0, aligned_data=4'b0011.
REQ-032 Stream pattern delayed by 2 bits (words 4'b1100) -> two mismatches, slip=2, lock after 8 matches, aligned_data=4'b0011.
REQ-033 Valid never asserted -> train_fail pulse at cycle 64 of ENABLE, rxen low 16 cycles, re-enters ENABLE; retry_cnt=1 with macro.
REQ-034 Random non-pattern words -> slip 0..3 visited, train_fail after 4th mismatch, BACKOFF entered.
REQ-035 In LOCKED pulse retrain while align_en drops same cycle -> IDLE next cycle, rxen=0; retrain alone -> BACKOFF, link_up=0 next cycle.
REQ-036 Assert axis_rst mid-SEARCH at slip=1 -> all outputs at reset values next cycle, no train_fail.

Source files
------------

// File: rtl/fsic_io_serdes_rx_align_ctrl.sv
// Serdes rx word aligner: trains a bit-slip offset against a fixed pattern, then forwards slipped words.
// Define FSIC_RX_ALIGN_RETRY_CNT_EN to add the saturating retry_cnt output.
//
// state    | meaning
// IDLE     | rx disabled, counters cleared, waiting for align_en
// ENABLE   | rx enabled, waiting up to pVALID_TIMEOUT cycles for valid words
// SEARCH   | testing each slip offset for pLOCK_CNT consecutive pattern matches
// LOCKED   | link up, slip frozen, aligned words forwarded
// BACKOFF  | rx disabled for pBACKOFF cycles before the next attempt
module fsic_io_serdes_rx_align_ctrl #(
  parameter int unsigned           pCLK_RATIO     = 4,
  parameter logic [pCLK_RATIO-1:0] pTRAIN_PATTERN = 4'b0011,
  parameter int unsigned           pLOCK_CNT      = 8,
  parameter int unsigned           pVALID_TIMEOUT = 64,
  parameter int unsigned           pBACKOFF       = 16
) (
  input  logic                          coreclk,
  input  logic                          axis_rst,
  input  logic                          align_en,
  input  logic                          retrain,
  input  logic [pCLK_RATIO-1:0]         rxdata_out,
  input  logic                          rxdata_out_valid,
  output logic                          rxen,
  output logic [pCLK_RATIO-1:0]         aligned_data,
  output logic                          aligned_valid,
  output logic                          link_up,
  output logic [$clog2(pCLK_RATIO)-1:0] slip,
`ifdef FSIC_RX_ALIGN_RETRY_CNT_EN
  output logic                          train_fail,
  output logic [7:0]                    retry_cnt
`else
  output logic                          train_fail
`endif
);

  localparam int SW = $clog2(pCLK_RATIO);
  localparam int MW = (pLOCK_CNT > 1) ? $clog2(pLOCK_CNT) : 1;
  localparam int EW = (pVALID_TIMEOUT > 1) ? $clog2(pVALID_TIMEOUT) : 1;
  localparam int BW = (pBACKOFF > 1) ? $clog2(pBACKOFF) : 1;

  localparam logic [MW-1:0] MATCH_LAST = MW'(pLOCK_CNT - 1);
  localparam logic [EW-1:0] EN_LAST    = EW'(pVALID_TIMEOUT - 1);
  localparam logic [BW-1:0] BO_LAST    = BW'(pBACKOFF - 1);
  localparam logic [SW-1:0] SLIP_LAST  = SW'(pCLK_RATIO - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENABLE,
    ST_SEARCH,
    ST_LOCKED,
    ST_BACKOFF
  } state_t;

  state_t                  state_q, state_d;
  logic [pCLK_RATIO-1:0]   prev_word_q;
  logic [SW-1:0]           slip_q, slip_d;
  logic [MW-1:0]           match_q, match_d;
  logic [EW-1:0]           en_tmr_q, en_tmr_d;
  logic [BW-1:0]           bo_tmr_q, bo_tmr_d;
  logic                    fail_d;
  logic                    avalid_d;
  logic [2*pCLK_RATIO-1:0] cat;
  logic [pCLK_RATIO-1:0]   candidate;

  // Previous word supplies the low half so any offset up to pCLK_RATIO-1 can be selected.
  assign cat       = {rxdata_out, prev_word_q};
  assign candidate = pCLK_RATIO'(cat >> slip_q);

  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    match_d  = match_q;
    en_tmr_d = en_tmr_q;
    bo_tmr_d = bo_tmr_q;
    fail_d   = 1'b0;
    if (!align_en) begin
      state_d  = ST_IDLE;
      slip_d   = '0;
      match_d  = '0;
      en_tmr_d = '0;
      bo_tmr_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_ENABLE;
          en_tmr_d = '0;
        end
        ST_ENABLE: begin
          if (rxdata_out_valid) begin
            state_d  = ST_SEARCH;
            en_tmr_d = '0;
          end else if (en_tmr_q == EN_LAST) begin
            state_d  = ST_BACKOFF;
            en_tmr_d = '0;
            bo_tmr_d = '0;
            slip_d   = '0;
            match_d  = '0;
            fail_d   = 1'b1;
          end else begin
            en_tmr_d = en_tmr_q + 1'b1;
          end
        end
        ST_SEARCH: begin
          if (rxdata_out_valid) begin
            if (candidate == pTRAIN_PATTERN) begin
              if (match_q == MATCH_LAST) begin
                state_d = ST_LOCKED;
              end else begin
                match_d = match_q + 1'b1;
              end
            end else if (slip_q == SLIP_LAST) begin
              // Every offset has been tried: give up this attempt.
              state_d  = ST_BACKOFF;
              bo_tmr_d = '0;
              slip_d   = '0;
              match_d  = '0;
              fail_d   = 1'b1;
            end else begin
              slip_d  = slip_q + 1'b1;
              match_d = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (retrain || !rxdata_out_valid) begin
            state_d  = ST_BACKOFF;
            bo_tmr_d = '0;
            slip_d   = '0;
            match_d  = '0;
          end
        end
        ST_BACKOFF: begin
          if (bo_tmr_q == BO_LAST) begin
            state_d  = ST_ENABLE;
            bo_tmr_d = '0;
            en_tmr_d = '0;
          end else begin
            bo_tmr_d = bo_tmr_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          slip_d  = '0;
          match_d = '0;
        end
      endcase
    end
  end

  // Only words arriving while the link stays up are forwarded; an exit cycle drops its word.
  assign avalid_d = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);

  always_ff @(posedge coreclk) begin
    if (axis_rst) begin
      state_q       <= ST_IDLE;
      prev_word_q   <= '0;
      slip_q        <= '0;
      match_q       <= '0;
      en_tmr_q      <= '0;
      bo_tmr_q      <= '0;
      train_fail    <= 1'b0;
      aligned_valid <= 1'b0;
      aligned_data  <= '0;
    end else begin
      state_q       <= state_d;
      slip_q        <= slip_d;
      match_q       <= match_d;
      en_tmr_q      <= en_tmr_d;
      bo_tmr_q      <= bo_tmr_d;
      train_fail    <= fail_d;
      aligned_valid <= avalid_d;
      aligned_data  <= avalid_d ? candidate : '0;
      if (rxdata_out_valid) begin
        prev_word_q <= rxdata_out;
      end
    end
  end

`ifdef FSIC_RX_ALIGN_RETRY_CNT_EN
  always_ff @(posedge coreclk) begin
    if (axis_rst) begin
      retry_cnt <= '0;
    end else if (fail_d && (retry_cnt != 8'hFF)) begin
      retry_cnt <= retry_cnt + 8'd1;
    end
  end
`endif

  assign rxen    = (state_q == ST_ENABLE) || (state_q == ST_SEARCH) || (state_q == ST_LOCKED);
  assign link_up = (state_q == ST_LOCKED);
  assign slip    = slip_q;

endmodule

// File: tb/tb_fsic_io_serdes_rx_align_ctrl.sv
// Directed bench for the rx aligner; aligned words are checked against a queue of
// expected values built from the bit-slip formula as each word is driven.
module tb_fsic_io_serdes_rx_align_ctrl;

  localparam logic [3:0] PAT = 4'b0011;

  logic       coreclk;
  logic       axis_rst;
  logic       align_en;
  logic       retrain;
  logic [3:0] rxdata_out;
  logic       rxdata_out_valid;
  logic       rxen;
  logic [3:0] aligned_data;
  logic       aligned_valid;
  logic       link_up;
  logic [1:0] slip;
  logic       train_fail;
`ifdef FSIC_RX_ALIGN_RETRY_CNT_EN
  logic [7:0] retry_cnt;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [3:0] sb[$];
  logic [3:0] m_prev = 4'd0;
  int exp_slip;

  fsic_io_serdes_rx_align_ctrl dut (
    .coreclk          (coreclk),
    .axis_rst         (axis_rst),
    .align_en         (align_en),
    .retrain          (retrain),
    .rxdata_out       (rxdata_out),
    .rxdata_out_valid (rxdata_out_valid),
    .rxen             (rxen),
    .aligned_data     (aligned_data),
    .aligned_valid    (aligned_valid),
    .link_up          (link_up),
    .slip             (slip),
    .train_fail       (train_fail)
`ifdef FSIC_RX_ALIGN_RETRY_CNT_EN
    , .retry_cnt      (retry_cnt)
`endif
  );

  initial coreclk = 1'b0;
  always #5 coreclk = ~coreclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cand(input logic [3:0] prev, input logic [3:0] cur, input int s);
    logic [7:0] c;
    c = {cur, prev};
    return 4'(c >> s);
  endfunction

  task automatic tick();
    @(posedge coreclk);
    if (axis_rst) m_prev = 4'd0;
    else if (rxdata_out_valid) m_prev = rxdata_out;
    #1;
  endtask

  task automatic send_locked(input logic [3:0] w);
    rxdata_out       = w;
    rxdata_out_valid = 1'b1;
    sb.push_back(cand(m_prev, w, exp_slip));
    tick();
    chk("locked_link_up", link_up, 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_rxen"}, rxen, 0);
    chk({pfx, "_aligned_data"}, aligned_data, 0);
    chk({pfx, "_aligned_valid"}, aligned_valid, 0);
    chk({pfx, "_link_up"}, link_up, 0);
    chk({pfx, "_slip"}, slip, 0);
    chk({pfx, "_train_fail"}, train_fail, 0);
  endtask

  function automatic logic [3:0] pick_mismatch(input logic [3:0] prev, input int s);
    logic [3:0] w;
    do w = 4'($urandom_range(0, 15)); while (cand(prev, w, s) == PAT);
    return w;
  endfunction

  always @(negedge coreclk) begin
    if (aligned_valid === 1'b1) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) chk("sb_aligned_data", aligned_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] w;
    axis_rst = 1'b1; align_en = 1'b0; retrain = 1'b0;
    rxdata_out = 4'd0; rxdata_out_valid = 1'b0;
    exp_slip = 0;
    repeat (3) tick();
    chk_reset_vals("rst");
`ifdef FSIC_RX_ALIGN_RETRY_CNT_EN
    chk("rst_retry_cnt", retry_cnt, 0);
`endif

    // Aligned stream at slip 0
    axis_rst = 1'b0; align_en = 1'b1;
    tick();
    chk("a_enable_rxen", rxen, 1);
    chk("a_enable_link", link_up, 0);
    tick();
    rxdata_out = PAT; rxdata_out_valid = 1'b1;
    n = 0;
    while (link_up !== 1'b1 && n < 40) begin tick(); n++; end
    chk("a_lock_latency", n, 9);
    chk("a_slip", slip, 0);
    chk("a_first_locked_valid", aligned_valid, 0);
    exp_slip = 0;
    send_locked(PAT);
    chk("a_aligned_pattern", aligned_data, PAT);
    repeat (6) send_locked(4'($urandom_range(0, 15)));

    // Retrain alone drops to BACKOFF without a fail pulse
    retrain = 1'b1; rxdata_out = PAT;
    tick();
    retrain = 1'b0; rxdata_out_valid = 1'b0;
    chk("a_retrain_link", link_up, 0);
    chk("a_retrain_av", aligned_valid, 0);
    chk("a_retrain_rxen", rxen, 0);
    chk("a_retrain_tf", train_fail, 0);
    chk("a_retrain_data", aligned_data, 0);
    n = 0;
    while (rxen !== 1'b1 && n < 100) begin n++; tick(); end
    chk("a_backoff_len", n, 16);

    // Stream delayed by two bits
    rxdata_out = 4'b1100; rxdata_out_valid = 1'b1;
    n = 0;
    while (link_up !== 1'b1 && n < 40) begin tick(); n++; end
    chk("b_lock_latency", n, 11);
    chk("b_slip", slip, 2);
    exp_slip = 2;
    send_locked(4'b1100);
    chk("b_aligned_pattern", aligned_data, PAT);
    repeat (5) send_locked(4'($urandom_range(0, 15)));
    rxdata_out_valid = 1'b0;
    tick();
    chk("b_novalid_link", link_up, 0);
    chk("b_novalid_av", aligned_valid, 0);
    chk("b_novalid_rxen", rxen, 0);
    chk("b_novalid_tf", train_fail, 0);

    // Relock, then retrain together with align_en low goes to IDLE
    rxdata_out = PAT; rxdata_out_valid = 1'b1;
    n = 0;
    while (link_up !== 1'b1 && n < 80) begin tick(); n++; end
    chk("d_relock", link_up, 1);
    retrain = 1'b1; align_en = 1'b0;
    tick();
    retrain = 1'b0;
    chk("d_idle_rxen", rxen, 0);
    chk("d_idle_link", link_up, 0);
    chk("d_idle_av", aligned_valid, 0);
    rxdata_out_valid = 1'b0; align_en = 1'b1;
    tick();
    chk("d_idle_to_enable", rxen, 1);

    // Valid timeout
    n = 0;
    while (rxen === 1'b1 && n < 200) begin n++; tick(); end
    chk("c_enable_len", n, 64);
    chk("c_tf_pulse", train_fail, 1);
    chk("c_backoff_rxen", rxen, 0);
`ifdef FSIC_RX_ALIGN_RETRY_CNT_EN
    chk("c_retry_cnt", retry_cnt, 1);
`endif
    tick();
    chk("c_tf_single", train_fail, 0);
    n = 1;
    while (rxen !== 1'b1 && n < 100) begin n++; tick(); end
    chk("c_backoff_len", n, 16);

    // Non-pattern words walk every slip then fail
    rxdata_out = 4'($urandom_range(0, 15)); rxdata_out_valid = 1'b1;
    tick();
    chk("e_search_rxen", rxen, 1);
    chk("e_search_slip", slip, 0);
    exp_slip = 0;
    for (int k = 0; k < 4; k++) begin
      w = pick_mismatch(m_prev, exp_slip);
      rxdata_out = w;
      retrain = (k == 0);
      tick();
      retrain = 1'b0;
      if (k < 3) begin
        exp_slip++;
        chk("e_slip_step", slip, exp_slip);
        chk("e_rxen_hold", rxen, 1);
        chk("e_no_tf", train_fail, 0);
      end else begin
        chk("e_fail_slip", slip, 0);
        chk("e_fail_rxen", rxen, 0);
        chk("e_fail_tf", train_fail, 1);
      end
    end
`ifdef FSIC_RX_ALIGN_RETRY_CNT_EN
    chk("e_retry_cnt", retry_cnt, 2);
`endif

    // Reset in SEARCH at slip 1
    rxdata_out_valid = 1'b0;
    n = 0;
    while (rxen !== 1'b1 && n < 100) begin n++; tick(); end
    chk("f_backoff_len", n, 16);
    rxdata_out = 4'($urandom_range(0, 15)); rxdata_out_valid = 1'b1;
    tick();
    rxdata_out = pick_mismatch(m_prev, 0);
    tick();
    chk("f_slip1", slip, 1);
    rxdata_out = pick_mismatch(m_prev, 1);
    axis_rst = 1'b1;
    tick();
    chk_reset_vals("f_rst");
`ifdef FSIC_RX_ALIGN_RETRY_CNT_EN
    chk("f_retry_cnt", retry_cnt, 0);
`endif
    axis_rst = 1'b0; align_en = 1'b0; rxdata_out_valid = 1'b0;
    tick();
    chk("f_idle_rxen", rxen, 0);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
